sync_fifo_ctrl: RTL and testbench

- Single-clock FIFO: a dual-port memory array plus write/read pointers, occupancy counter and status flags, all in one module.
- Generalises the fall-through / registered read dual-port memory into a complete buffer.
- Adds full/empty, programmable almost-full/almost-empty, level output and synchronous flush.
- Used wherever producer and consumer share a clock, alongside the async FIFO for clock-crossing paths.

---
 rtl/sync_fifo_ctrl_if.sv | 39 +++
 rtl/sync_fifo_ctrl.sv | 126 ++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for sync_fifo_ctrl.
// The overflow/underflow pair exists only when SYNC_FIFO_ERR_FLAGS_EN is defined.
interface sync_fifo_ctrl_if #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
);
  logic                flush;
  logic                winc;
  logic [DATASIZE-1:0] wdata;
  logic                wfull;
  logic                awfull;
  logic                rinc;
  logic [DATASIZE-1:0] rdata;
  logic                rempty;
  logic                arempty;
  logic [ADDRSIZE:0]   level;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic                overflow;
  logic                underflow;

  modport master (
    output flush, winc, wdata, rinc,
    input  wfull, awfull, rdata, rempty, arempty, level, overflow, underflow
  );
  modport slave (
    input  flush, winc, wdata, rinc,
    output wfull, awfull, rdata, rempty, arempty, level, overflow, underflow
  );
`else
  modport master (
    output flush, winc, wdata, rinc,
    input  wfull, awfull, rdata, rempty, arempty, level
  );
  modport slave (
    input  flush, winc, wdata, rinc,
    output wfull, awfull, rdata, rempty, arempty, level
  );
`endif
endinterface

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO: memory array, binary pointers, occupancy counter and level-decoded flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo_ctrl #(
  parameter int    DATASIZE         = 8,
  parameter int    ADDRSIZE         = 4,
  parameter string FALLTHROUGH      = "TRUE",
  parameter int    ALMOST_FULL_LVL  = 2,
  parameter int    ALMOST_EMPTY_LVL = 2
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_ctrl_if.slave fifo
);
  localparam int DEPTH = 1 << ADDRSIZE;
  localparam logic [ADDRSIZE:0] PTR_ONE  = {{ADDRSIZE{1'b0}}, 1'b1};
  localparam logic [ADDRSIZE:0] FULL_LVL = (ADDRSIZE+1)'(DEPTH);
  localparam logic [ADDRSIZE:0] AFULL_TH = (ADDRSIZE+1)'(DEPTH - ALMOST_FULL_LVL);
  localparam logic [ADDRSIZE:0] AEMPT_TH = (ADDRSIZE+1)'(ALMOST_EMPTY_LVL);

  generate
    if (ALMOST_FULL_LVL < 1 || ALMOST_FULL_LVL > DEPTH - 1) begin : g_bad_afull
      $error("sync_fifo_ctrl: ALMOST_FULL_LVL out of range 1..DEPTH-1");
    end
    if (ALMOST_EMPTY_LVL < 1 || ALMOST_EMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
      $error("sync_fifo_ctrl: ALMOST_EMPTY_LVL out of range 1..DEPTH-1");
    end
    if (FALLTHROUGH != "TRUE" && FALLTHROUGH != "FALSE") begin : g_bad_mode
      $error("sync_fifo_ctrl: FALLTHROUGH must be \"TRUE\" or \"FALSE\"");
    end
  endgenerate

  logic [DATASIZE-1:0] mem [DEPTH];

  logic [ADDRSIZE:0]   wptr_reg, wptr_next;
  logic [ADDRSIZE:0]   rptr_reg, rptr_next;
  logic [ADDRSIZE:0]   level_reg, level_next;
  logic [ADDRSIZE-1:0] waddr, raddr;
  logic                full_flag, empty_flag;
  logic                wr_en, rd_en;

  assign waddr      = wptr_reg[ADDRSIZE-1:0];
  assign raddr      = rptr_reg[ADDRSIZE-1:0];
  assign full_flag  = (level_reg == FULL_LVL);
  assign empty_flag = (level_reg == '0);

  // Flush wins over both requests, so it also blocks the memory write.
  assign wr_en = fifo.winc & ~full_flag  & ~fifo.flush;
  assign rd_en = fifo.rinc & ~empty_flag & ~fifo.flush;

  always_comb begin
    wptr_next  = wptr_reg;
    rptr_next  = rptr_reg;
    level_next = level_reg;
    if (fifo.flush) begin
      wptr_next  = '0;
      rptr_next  = '0;
      level_next = '0;
    end else begin
      if (wr_en) wptr_next = wptr_reg + PTR_ONE;
      if (rd_en) rptr_next = rptr_reg + PTR_ONE;
      case ({wr_en, rd_en})
        2'b10:   level_next = level_reg + PTR_ONE;
        2'b01:   level_next = level_reg - PTR_ONE;
        default: level_next = level_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      level_reg <= '0;
    end else begin
      wptr_reg  <= wptr_next;
      rptr_reg  <= rptr_next;
      level_reg <= level_next;
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= fifo.wdata;
  end

  assign fifo.wfull   = full_flag;
  assign fifo.rempty  = empty_flag;
  assign fifo.awfull  = (level_reg >= AFULL_TH);
  assign fifo.arempty = (level_reg <= AEMPT_TH);
  assign fifo.level   = level_reg;

  generate
    if (FALLTHROUGH == "TRUE") begin : g_fallthrough
      assign fifo.rdata = mem[raddr];
    end else begin : g_registered
      logic [DATASIZE-1:0] rdata_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)             rdata_reg <= '0;
        else if (fifo.flush) rdata_reg <= '0;
        else if (rd_en)      rdata_reg <= mem[raddr];
      end
      assign fifo.rdata = rdata_reg;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_reg, underflow_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else if (fifo.flush) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (fifo.winc & full_flag)  overflow_reg  <= 1'b1;
      if (fifo.rinc & empty_flag) underflow_reg <= 1'b1;
    end
  end

  assign fifo.overflow  = overflow_reg;
  assign fifo.underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Drives a fall-through and a registered-read FIFO with identical stimulus and
// checks both against a queue-based reference every cycle.
module tb_sync_fifo_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_ctrl_if #(.DATASIZE(8), .ADDRSIZE(4)) fi_ft ();
  sync_fifo_ctrl_if #(.DATASIZE(8), .ADDRSIZE(4)) fi_rg ();

  sync_fifo_ctrl #(.DATASIZE(8), .ADDRSIZE(4), .FALLTHROUGH("TRUE"),
                   .ALMOST_FULL_LVL(2), .ALMOST_EMPTY_LVL(2))
    dut_ft (.clk(clk), .rst(rst), .fifo(fi_ft));

  sync_fifo_ctrl #(.DATASIZE(8), .ADDRSIZE(4), .FALLTHROUGH("FALSE"),
                   .ALMOST_FULL_LVL(2), .ALMOST_EMPTY_LVL(2))
    dut_rg (.clk(clk), .rst(rst), .fifo(fi_rg));

  // Reference model: contents queue, registered-read word, sticky error flags.
  logic [7:0] q[$];
  logic [7:0] rreg = 8'h00;
  bit ovf = 1'b0;
  bit unf = 1'b0;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;
  int cmp_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit w, input logic [7:0] d, input bit r, input bit f);
    fi_ft.winc = w; fi_ft.wdata = d; fi_ft.rinc = r; fi_ft.flush = f;
    fi_rg.winc = w; fi_rg.wdata = d; fi_rg.rinc = r; fi_rg.flush = f;
  endtask

  task automatic model_reset();
    q.delete();
    rreg = 8'h00;
    ovf  = 1'b0;
    unf  = 1'b0;
  endtask

  // One clock of stimulus; model advances from its pre-edge state, inputs settle 1 after edge.
  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit f);
    int n;
    drive(w, d, r, f);
    n = q.size();
    @(posedge clk);
    if (f) begin
      q.delete();
      rreg = 8'h00;
      ovf  = 1'b0;
      unf  = 1'b0;
    end else begin
      if (w && n == 16) ovf = 1'b1;
      if (r && n == 0)  unf = 1'b1;
      if (r && n > 0)   rreg = q.pop_front();
      if (w && n < 16)  q.push_back(d);
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      cmp_n = q.size();
      chk("level_ft",   fi_ft.level,   cmp_n);
      chk("level_rg",   fi_rg.level,   cmp_n);
      chk("wfull_ft",   fi_ft.wfull,   32'(cmp_n == 16));
      chk("wfull_rg",   fi_rg.wfull,   32'(cmp_n == 16));
      chk("rempty_ft",  fi_ft.rempty,  32'(cmp_n == 0));
      chk("rempty_rg",  fi_rg.rempty,  32'(cmp_n == 0));
      chk("awfull_ft",  fi_ft.awfull,  32'(cmp_n >= 14));
      chk("arempty_ft", fi_ft.arempty, 32'(cmp_n <= 2));
      chk("awfull_rg",  fi_rg.awfull,  32'(cmp_n >= 14));
      chk("arempty_rg", fi_rg.arempty, 32'(cmp_n <= 2));
      if (cmp_n > 0) chk("rdata_ft", fi_ft.rdata, q[0]);
      chk("rdata_rg", fi_rg.rdata, rreg);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
      chk("overflow",  fi_ft.overflow,  ovf);
      chk("underflow", fi_ft.underflow, unf);
      chk("overflow_rg",  fi_rg.overflow,  ovf);
      chk("underflow_rg", fi_rg.underflow, unf);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #2;
    chk("rst_level",   fi_ft.level,   0);
    chk("rst_rempty",  fi_ft.rempty,  1);
    chk("rst_arempty", fi_ft.arempty, 1);
    chk("rst_wfull",   fi_ft.wfull,   0);
    chk("rst_awfull",  fi_ft.awfull,  0);
    chk("rst_rdata_rg", fi_rg.rdata,  0);
    @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;

    // Fall-through single word
    step(1'b1, 8'h11, 1'b0, 1'b0);
    chk("ft1_rempty", fi_ft.rempty, 0);
    chk("ft1_level",  fi_ft.level,  1);
    chk("ft1_rdata",  fi_ft.rdata,  8'h11);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ft1_rd_rempty", fi_ft.rempty, 1);
    chk("ft1_rd_level",  fi_ft.level,  0);

    // Fill to full, overflow attempt, drain in order
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 12) chk("fill_awfull13", fi_ft.awfull, 0);
      if (i == 13) chk("fill_awfull14", fi_ft.awfull, 1);
      if (i == 14) chk("fill_wfull15",  fi_ft.wfull,  0);
    end
    chk("fill_wfull16", fi_ft.wfull, 1);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("ovf_level", fi_ft.level, 16);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("ovf_flag", fi_ft.overflow, 1);
`endif
    for (int i = 0; i < 16; i++) begin
      chk("drain_ft", fi_ft.rdata, 8'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain_rg", fi_rg.rdata, 8'(i));
      if (i == 12) chk("drain_arempty3", fi_ft.arempty, 0);
      if (i == 13) chk("drain_arempty2", fi_ft.arempty, 1);
    end
    chk("drain_empty", fi_ft.rempty, 1);

    // Registered read
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rg_first", fi_rg.rdata, 8'hA5);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rg_second", fi_rg.rdata, 8'h5A);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    chk("rg_hold", fi_rg.rdata, 8'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap with simultaneous read/write at level 8
    k = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(k), 1'b0, 1'b0);
      k++;
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(k), 1'b1, 1'b0);
      k++;
    end
    chk("wrap_level", fi_ft.level, 8);
    chk("wrap_rg",    fi_rg.rdata, 8'd39);
    chk("wrap_ft",    fi_ft.rdata, 8'd40);

    // Flush beats simultaneous requests
    step(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("pre_flush_level", fi_ft.level, 5);
    step(1'b1, 8'h77, 1'b1, 1'b1);
    chk("flush_level",  fi_ft.level,  0);
    chk("flush_rempty", fi_ft.rempty, 1);
    chk("flush_rg",     fi_rg.rdata,  0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    chk("post_flush_ft", fi_ft.rdata, 8'h33);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_flush_rg", fi_rg.rdata, 8'h33);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    chk("pre_rst_level", fi_ft.level, 9);
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("arst_level",   fi_ft.level,   0);
    chk("arst_rempty",  fi_ft.rempty,  1);
    chk("arst_arempty", fi_ft.arempty, 1);
    chk("arst_awfull",  fi_ft.awfull,  0);
    chk("arst_rg",      fi_rg.rdata,   0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post_rst_level", fi_ft.level, 0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("post_rst_underflow", fi_ft.underflow, 1);
`endif

    // Randomized traffic: write-heavy, then read-heavy, with rare flushes
    for (int i = 0; i < 600; i++) begin
      bit w, r, f;
      if (i < 300) begin
        w = ($urandom_range(3) != 0);
        r = ($urandom_range(3) == 0);
      end else begin
        w = ($urandom_range(3) == 0);
        r = ($urandom_range(3) != 0);
      end
      f = ($urandom_range(79) == 0);
      step(w, 8'($urandom), r, f);
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
